// File: rtl/jtopl_acc_seq_if.sv
// Bundle between the slot sequencer and the accumulator path.
// The operator side (master) drives the clock enable and the channel/rhythm settings.
interface jtopl_acc_seq_if;
    logic        cenop;
    logic [8:0]  con_ch;
    logic        rhy_in;
    logic [17:0] slot;
    logic        op;
    logic        con;
    logic        zero;
    logic        rhy_en;
    logic [3:0]  ch;
    logic        sample;

    modport master (
        output cenop, con_ch, rhy_in,
        input  slot, op, con, zero, rhy_en, ch, sample
    );

    modport slave (
        input  cenop, con_ch, rhy_in,
        output slot, op, con, zero, rhy_en, ch, sample
    );
endinterface

// File: rtl/jtopl_acc_seq.sv
// 18-slot frame sequencer for the output accumulator: issue slot, pipeline-delayed
// slot control, frame-shadowed connection/rhythm settings and a per-frame sample strobe.
module jtopl_acc_seq #(
    parameter int PIPE_LAT = 2
) (
    input logic            clk,
    input logic            rst_n,
    jtopl_acc_seq_if.slave bus
);

    localparam int         DL  = (PIPE_LAT > 0) ? PIPE_LAT : 1;
    localparam logic [2:0] LAT = 3'(PIPE_LAT);

    // Slot number -> {carrier flag, channel}; groups of six are mod x3 then car x3.
    function automatic logic [4:0] slot_map(input logic [4:0] s);
        logic [4:0] r;
        case (s)
            5'd0:    r = {1'b0, 4'd0};
            5'd1:    r = {1'b0, 4'd1};
            5'd2:    r = {1'b0, 4'd2};
            5'd3:    r = {1'b1, 4'd0};
            5'd4:    r = {1'b1, 4'd1};
            5'd5:    r = {1'b1, 4'd2};
            5'd6:    r = {1'b0, 4'd3};
            5'd7:    r = {1'b0, 4'd4};
            5'd8:    r = {1'b0, 4'd5};
            5'd9:    r = {1'b1, 4'd3};
            5'd10:   r = {1'b1, 4'd4};
            5'd11:   r = {1'b1, 4'd5};
            5'd12:   r = {1'b0, 4'd6};
            5'd13:   r = {1'b0, 4'd7};
            5'd14:   r = {1'b0, 4'd8};
            5'd15:   r = {1'b1, 4'd6};
            5'd16:   r = {1'b1, 4'd7};
            5'd17:   r = {1'b1, 4'd8};
            default: r = 5'd0;
        endcase
        return r;
    endfunction

    logic [4:0]  cnt_q, cnt_d;
    logic [4:0]  dl_q [DL];
    logic [4:0]  dl_d [DL];
    logic [4:0]  dcnt_q, dcnt_d;
    logic [2:0]  wcnt_q, wcnt_d;
    logic        warm_q, warm_d;
    logic        fdone_q, fdone_d;
    logic [8:0]  con_sh_q, con_sh_d;
    logic        rhy_sh_q, rhy_sh_d;
    logic [17:0] slot_q, slot_d;
    logic        op_q, op_d;
    logic        con_q, con_d;
    logic        zero_q, zero_d;
    logic        rhy_en_q, rhy_en_d;
    logic [3:0]  ch_q, ch_d;
    logic        sample_q, sample_d;
    logic [4:0]  map;
    logic        load;

    always_comb begin
        cnt_d    = cnt_q;
        dl_d     = dl_q;
        wcnt_d   = wcnt_q;
        warm_d   = warm_q;
        fdone_d  = fdone_q;
        con_sh_d = con_sh_q;
        rhy_sh_d = rhy_sh_q;
        slot_d   = slot_q;
        op_d     = op_q;
        con_d    = con_q;
        zero_d   = zero_q;
        rhy_en_d = rhy_en_q;
        ch_d     = ch_q;
        sample_d = sample_q;
        load     = 1'b0;

        if (bus.cenop) begin
            cnt_d   = (cnt_q == 5'd17) ? 5'd0 : cnt_q + 5'd1;
            dl_d[0] = cnt_q;
            for (int i = 1; i < DL; i++) begin
                dl_d[i] = dl_q[i-1];
            end
        end

        dcnt_q = (PIPE_LAT == 0) ? cnt_q : dl_q[DL-1];
        dcnt_d = (PIPE_LAT == 0) ? cnt_d : dl_d[DL-1];
        map    = slot_map(dcnt_d);

        if (bus.cenop) begin
            if (!warm_q) begin
                wcnt_d = wcnt_q + 3'd1;
                warm_d = (wcnt_q + 3'd1) >= LAT;
            end

            // Settings take effect from delayed slot 0 so a frame is never mixed.
            load = warm_d && (dcnt_d == 5'd0);
            if (load) begin
                con_sh_d = bus.con_ch;
                rhy_sh_d = bus.rhy_in;
            end

            if (warm_q && dcnt_q == 5'd17 && dcnt_d == 5'd0) begin
                fdone_d = 1'b1;
            end

            slot_d   = 18'd1 << cnt_d;
            op_d     = warm_d & map[4];
            ch_d     = map[3:0];
            zero_d   = warm_d & (dcnt_d == 5'd0);
            con_d    = warm_d & con_sh_d[map[3:0]];
            rhy_en_d = rhy_sh_d;
            sample_d = zero_d & fdone_d;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_q    <= 5'd0;
            for (int i = 0; i < DL; i++) begin
                dl_q[i] <= 5'd0;
            end
            wcnt_q   <= 3'd0;
            warm_q   <= 1'b0;
            fdone_q  <= 1'b0;
            con_sh_q <= 9'd0;
            rhy_sh_q <= 1'b0;
            slot_q   <= 18'h1;
            op_q     <= 1'b0;
            con_q    <= 1'b0;
            zero_q   <= 1'b0;
            rhy_en_q <= 1'b0;
            ch_q     <= 4'd0;
            sample_q <= 1'b0;
        end else begin
            cnt_q    <= cnt_d;
            dl_q     <= dl_d;
            wcnt_q   <= wcnt_d;
            warm_q   <= warm_d;
            fdone_q  <= fdone_d;
            con_sh_q <= con_sh_d;
            rhy_sh_q <= rhy_sh_d;
            slot_q   <= slot_d;
            op_q     <= op_d;
            con_q    <= con_d;
            zero_q   <= zero_d;
            rhy_en_q <= rhy_en_d;
            ch_q     <= ch_d;
            sample_q <= sample_d;
        end
    end

    assign bus.slot   = slot_q;
    assign bus.op     = op_q;
    assign bus.con    = con_q;
    assign bus.zero   = zero_q;
    assign bus.rhy_en = rhy_en_q;
    assign bus.ch     = ch_q;
    assign bus.sample = sample_q;

endmodule
